inst_fetch_queue: RTL and testbench

Parametrised instruction fetch unit for the out-of-order RISC-V core. It sits between the memory controller and the issue stage. It issues one outstanding instruction-fetch request at a time and buffers returned instructions in a QUEUE_DEPTH-entry FIFO. It halts after a JALR until the ROB redirects, and it discards in-flight responses on a flush. Optionally, it follows JAL targets at fetch time.

---
 rtl/inst_fetch_queue_if.sv | 41 ++++
 rtl/inst_fetch_queue.sv | 188 ++++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_if
//   Memory-side and issue-side signal bundle of the instruction fetch queue.
//   master : the fetch queue (drives requests, presents queue head)
//   slave  : the environment (memory controller + issue stage)
//
//   _mem_req/_mem_addr      fetch request, level, address = fetch PC
//   _mem_busy               memory cannot accept a request this cycle
//   _mem_valid/_mem_inst    one-cycle response strobe + instruction word
//   _inst_valid/_inst/...   queue head (instruction, its PC, predicted next PC)
//   _inst_ready             issue accepts the head this cycle
//   _queue_count            occupied queue entries
// ---------------------------------------------------------------------------
interface inst_fetch_queue_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int QUEUE_DEPTH = 4
);
   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   logic                  _mem_req;
   logic [ADDR_WIDTH-1:0] _mem_addr;
   logic                  _mem_busy;
   logic                  _mem_valid;
   logic [31:0]           _mem_inst;
   logic                  _inst_valid;
   logic [31:0]           _inst;
   logic [ADDR_WIDTH-1:0] _inst_addr;
   logic [ADDR_WIDTH-1:0] _inst_pred_pc;
   logic                  _inst_ready;
   logic [CNT_W-1:0]      _queue_count;

   modport master (
      output _mem_req, _mem_addr, _inst_valid, _inst, _inst_addr, _inst_pred_pc, _queue_count,
      input  _mem_busy, _mem_valid, _mem_inst, _inst_ready
   );

   modport slave (
      input  _mem_req, _mem_addr, _inst_valid, _inst, _inst_addr, _inst_pred_pc, _queue_count,
      output _mem_busy, _mem_valid, _mem_inst, _inst_ready
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction fetch unit between the memory controller and the issue stage.
//   Keeps at most one fetch request outstanding and buffers returned words in
//   a QUEUE_DEPTH-entry FIFO. Stops fetching after a JALR until the ROB
//   redirects with _clear; a flush discards any in-flight response.
//
//   Optional feature macro: FETCH_JAL_PREDICT_EN
//     defined   : a returned JAL steers fetch to its target at fetch time and
//                 the entry's predicted PC carries that target
//     undefined : every non-JALR word continues at PC+4
//
// Ports
//   clk_in        system clock, rising edge
//   rst_in        asynchronous active-high reset
//   rdy_in        global pause; low freezes all state and masks
//                 _mem_req / _inst_valid
//   _clear        flush queue and redirect fetch (highest priority)
//   _redirect_pc  new fetch PC, sampled with _clear
//   bus           inst_fetch_queue_if.master (memory + issue handshakes)
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
   parameter int                    QUEUE_DEPTH = 4,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  _clear,
   input  logic [ADDR_WIDTH-1:0] _redirect_pc,
   inst_fetch_queue_if.master    bus
);

   localparam int         PTR_W   = $clog2(QUEUE_DEPTH);
   localparam int         CNT_W   = PTR_W + 1;
   localparam logic [6:0] OP_JALR = 7'b1100111;
`ifdef FETCH_JAL_PREDICT_EN
   localparam logic [6:0] OP_JAL  = 7'b1101111;
`endif

   typedef enum logic [1:0] {
      S_IDLE,   // may request
      S_WAIT,   // request accepted, awaiting its response
      S_DROP,   // flushed request still in flight, response is discarded
      S_HOLD    // JALR fetched, wait for redirect
   } state_t;

   typedef struct packed {
      logic [31:0]           inst;
      logic [ADDR_WIDTH-1:0] addr;
      logic [ADDR_WIDTH-1:0] pred;
   } entry_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q;
   logic [ADDR_WIDTH-1:0] req_addr_q;
   logic [PTR_W-1:0]      head_q, tail_q;
   logic [CNT_W-1:0]      count_q;
   entry_t                queue_q [QUEUE_DEPTH];

   logic                  not_full;
   logic                  mem_req;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  resp_jalr;
   logic                  q_nonempty;
   logic [ADDR_WIDTH-1:0] next_pc;
   entry_t                head;

   // ------------------------------------------------------------------------
   // Handshake decode. _clear masks request, push and pop; rdy_in low masks
   // everything so the whole unit freezes.
   // ------------------------------------------------------------------------
   assign q_nonempty = (count_q != '0);
   assign not_full   = (count_q < CNT_W'(QUEUE_DEPTH));
   assign mem_req    = !rst_in && rdy_in && !_clear && (state_q == S_IDLE) && not_full;
   assign accept     = mem_req && !bus._mem_busy;
   assign push       = rdy_in && !_clear && (state_q == S_WAIT) && bus._mem_valid;
   assign pop        = rdy_in && !_clear && q_nonempty && bus._inst_ready;
   assign resp_jalr  = (bus._mem_inst[6:0] == OP_JALR);

   // Predicted next fetch PC for the returning word; addition wraps
   // modulo 2^ADDR_WIDTH.
`ifdef FETCH_JAL_PREDICT_EN
   logic [ADDR_WIDTH-1:0] jal_imm;
   assign jal_imm = ADDR_WIDTH'($signed({bus._mem_inst[31], bus._mem_inst[19:12],
                                         bus._mem_inst[20], bus._mem_inst[30:21], 1'b0}));

   always_comb begin
      next_pc = req_addr_q + ADDR_WIDTH'(4);
      if (bus._mem_inst[6:0] == OP_JAL)
         next_pc = req_addr_q + jal_imm;
   end
`else
   always_comb begin
      next_pc = req_addr_q + ADDR_WIDTH'(4);
   end
`endif

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (rdy_in) begin
         if (_clear) begin
            // A request still awaiting its response must have that response
            // swallowed, otherwise it would be taken as the answer to the
            // first request at the redirect PC. This also holds when already
            // in DROP and flushed again.
            if ((state_q == S_WAIT || state_q == S_DROP) && !bus._mem_valid)
               state_d = S_DROP;
            else
               state_d = S_IDLE;
         end else begin
            case (state_q)
               S_IDLE:  if (accept)                   state_d = S_WAIT;
               S_WAIT:  if (bus._mem_valid)           state_d = resp_jalr ? S_HOLD : S_IDLE;
               S_DROP:  if (bus._mem_valid)           state_d = S_IDLE;
               S_HOLD:                                state_d = S_HOLD;
               default:                               state_d = S_IDLE;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Fetch PC, request address and FIFO. Pointers wrap naturally because
   // QUEUE_DEPTH is a power of two. A push can never hit a full queue: a
   // request is only raised with room for its response.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         fetch_pc_q <= RESET_PC;
         req_addr_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++)
            queue_q[i] <= '0;
      end else if (rdy_in) begin
         if (_clear) begin
            fetch_pc_q <= _redirect_pc;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
         end else begin
            if (accept)
               req_addr_q <= fetch_pc_q;
            if (push) begin
               queue_q[tail_q] <= '{inst: bus._mem_inst, addr: req_addr_q, pred: next_pc};
               tail_q          <= tail_q + 1'b1;
               fetch_pc_q      <= next_pc;
            end
            if (pop)
               head_q <= head_q + 1'b1;
            if (push && !pop)
               count_q <= count_q + 1'b1;
            else if (pop && !push)
               count_q <= count_q - 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: head fields come straight from storage and read as zero when
   // the queue is empty; no bypass from the incoming response.
   // ------------------------------------------------------------------------
   assign head = q_nonempty ? queue_q[head_q] : '0;

   assign bus._mem_req      = mem_req;
   assign bus._mem_addr     = fetch_pc_q;
   assign bus._inst_valid   = rdy_in && q_nonempty;
   assign bus._inst         = head.inst;
   assign bus._inst_addr    = head.addr;
   assign bus._inst_pred_pc = head.pred;
   assign bus._queue_count  = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
   localparam int              QD     = 4;
   localparam int              AW     = 32;
   localparam logic [AW-1:0]   RST_PC = 32'h0;
   localparam logic [31:0]     W_JALR = 32'h0000_80E7;
   localparam logic [31:0]     W_JAL  = 32'h1000_006F;   // jal x0, +0x100
   localparam logic [31:0]     W_ADDI = 32'h0000_0013;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          rdy_in = 1'b1;
   logic          _clear = 1'b0;
   logic [AW-1:0] _redirect_pc = '0;

   inst_fetch_queue_if #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(QD)) bus ();

   inst_fetch_queue #(.QUEUE_DEPTH(QD), .ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      ._clear       (_clear),
      ._redirect_pc (_redirect_pc),
      .bus          (bus)
   );

   always #5 clk_in = ~clk_in;

   // ---------------- reference model state ----------------
   typedef struct {
      logic [31:0]   inst;
      logic [AW-1:0] addr;
      logic [AW-1:0] pred;
   } exp_t;

   exp_t          exp_q[$];      // expected queue contents, head first
   logic [AW-1:0] m_pc;          // next fetch address
   logic [AW-1:0] m_req_addr;    // address of outstanding request
   bit            m_halt, m_out, m_drop;
   logic [31:0]   prog [256];

   // ---------------- memory model ----------------
   bit            mem_pend;
   int            mem_lat;
   logic [AW-1:0] mem_addr;

   // ---------------- knobs ----------------
   int p_ready, p_busy, p_clear, p_pause, min_lat, max_lat;
   int rst_cycles, force_pause, pause_at, clr_mode;
   logic [AW-1:0] clr_pc;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] model_next(input logic [31:0] w, input logic [AW-1:0] a);
      int imm;
      model_next = a + 32'd4;
      imm = 0;
`ifdef FETCH_JAL_PREDICT_EN
      if (w[6:0] == 7'b1101111) begin
         imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
               + int'(w[30:21]) * 2;
         model_next = a + AW'(imm);
      end
`endif
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      m_pc       = RST_PC;
      m_req_addr = '0;
      m_halt     = 0;
      m_out      = 0;
      m_drop     = 0;
   endfunction

   // ---------------- monitor: compares outputs against the model ----------------
   initial begin : monitor
      bit exp_req;
      forever begin
         @(negedge clk_in);
         #1;
         if (rst_in) begin
            check("rst_mem_req",   bus._mem_req,      64'd0);
            check("rst_mem_addr",  bus._mem_addr,     RST_PC);
            check("rst_inst_vld",  bus._inst_valid,   64'd0);
            check("rst_inst",      bus._inst,         64'd0);
            check("rst_inst_addr", bus._inst_addr,    64'd0);
            check("rst_pred",      bus._inst_pred_pc, 64'd0);
            check("rst_count",     bus._queue_count,  64'd0);
         end else begin
            exp_req = rdy_in && !_clear && !m_halt && !m_out && (exp_q.size() < QD);
            check("mem_req",     bus._mem_req,     exp_req);
            check("mem_addr",    bus._mem_addr,    m_pc);
            check("queue_count", bus._queue_count, exp_q.size());
            check("inst_valid",  bus._inst_valid,  rdy_in && (exp_q.size() > 0));
            if (exp_q.size() > 0) begin
               check("inst",      bus._inst,         exp_q[0].inst);
               check("inst_addr", bus._inst_addr,    exp_q[0].addr);
               check("pred_pc",   bus._inst_pred_pc, exp_q[0].pred);
               if (rdy_in && !_clear && bus._inst_ready)
                  void'(exp_q.pop_front());
            end else begin
               check("empty_inst",  bus._inst,         64'd0);
               check("empty_addr",  bus._inst_addr,    64'd0);
               check("empty_pred",  bus._inst_pred_pc, 64'd0);
            end
         end
      end
   end

   // ---------------- stimulus: one clock cycle ----------------
   task automatic cycle();
      bit            valid, m_acc, fire;
      logic [31:0]   w;
      logic [AW-1:0] nxt;
      @(negedge clk_in);
      rst_in = (rst_cycles > 0);
      if (rst_cycles > 0) rst_cycles--;
      if (pause_at >= 0 && exp_q.size() == pause_at && !rst_in) begin
         force_pause = 3;
         pause_at    = -1;
      end
      if (force_pause > 0) begin
         rdy_in = 1'b0;
         force_pause--;
      end else
         rdy_in = ($urandom_range(99) >= p_pause);
      bus._inst_ready = ($urandom_range(99) < p_ready);
      bus._mem_busy   = ($urandom_range(99) < p_busy);

      // memory response
      valid = 0;
      if (mem_pend && rst_in)
         mem_lat = 0;
      else if (mem_pend && rdy_in) begin
         if (mem_lat == 0) begin
            valid    = 1;
            mem_pend = 0;
         end else
            mem_lat--;
      end
      w = valid ? prog[mem_addr[9:2]] : $urandom;
      bus._mem_valid = valid;
      bus._mem_inst  = w;

      // flush
      _clear       = 1'b0;
      _redirect_pc = $urandom;
      fire         = 0;
      if (rdy_in && !rst_in) begin
         case (clr_mode)
            1:       fire = 1;
            2:       fire = m_out && !m_drop && !valid;
            3:       fire = valid && m_out && !m_drop;
            default: fire = 0;
         endcase
         if (fire) begin
            _clear       = 1'b1;
            _redirect_pc = clr_pc;
            clr_mode     = 0;
         end else if (clr_mode == 0 && $urandom_range(999) < p_clear) begin
            _clear       = 1'b1;
            _redirect_pc = AW'($urandom_range(0, 255) * 4);
         end
      end

      m_acc = rdy_in && !rst_in && !_clear && !m_halt && !m_out && (exp_q.size() < QD)
              && !bus._mem_busy;
      #2;
      if (bus._mem_req && !bus._mem_busy) begin
         mem_pend = 1;
         mem_addr = bus._mem_addr;
         mem_lat  = $urandom_range(min_lat, max_lat);
      end

      // model update for the coming edge
      if (rst_in)
         model_reset();
      else if (rdy_in) begin
         if (_clear) begin
            exp_q.delete();
            m_pc   = _redirect_pc;
            m_halt = 0;
            if (valid) begin
               m_out  = 0;
               m_drop = 0;
            end else if (m_out)
               m_drop = 1;
         end else begin
            if (valid && m_out) begin
               m_out = 0;
               if (m_drop)
                  m_drop = 0;
               else begin
                  nxt = model_next(w, m_req_addr);
                  exp_q.push_back('{w, m_req_addr, nxt});
                  m_pc   = nxt;
                  m_halt = (w[6:0] == 7'b1100111);
               end
            end
            if (m_acc) begin
               m_out      = 1;
               m_req_addr = m_pc;
            end
         end
      end
   endtask

   task automatic knobs(input int rdy_p, input int busy_p, input int lmin, input int lmax);
      p_ready = rdy_p;
      p_busy  = busy_p;
      min_lat = lmin;
      max_lat = lmax;
      p_clear = 0;
      p_pause = 0;
   endtask

   initial begin : stimulus
      for (int i = 0; i < 256; i++) begin
         int r;
         logic [31:0] wd;
         wd = $urandom;
         wd[6:0] = 7'b0010011;
         r = $urandom_range(99);
         if (r < 5)       wd = W_JALR;
         else if (r < 10) wd = ($urandom & 32'h81E0_0000) | 32'h0000_006F;
         prog[i] = wd;
      end
      for (int i = 0; i < 20; i++) prog[i] = W_ADDI | (i << 20);
      prog[72] = W_ADDI;
      bus._inst_ready = 0;
      bus._mem_busy   = 0;
      bus._mem_valid  = 0;
      bus._mem_inst   = '0;
      mem_pend = 0; mem_lat = 0; mem_addr = '0;
      force_pause = 0; pause_at = -1; clr_mode = 0; clr_pc = '0;
      model_reset();
      knobs(0, 0, 0, 0);
      rst_cycles = 2;

      // fill the queue from reset, then pop one entry
      repeat (14) cycle();
      check("fill_count", bus._queue_count, QD);
      check("fill_noreq", bus._mem_req, 64'd0);
      p_ready = 100;
      cycle();
      p_ready = 0;
      repeat (8) cycle();
      check("refill_count", bus._queue_count, QD);

      // JALR halts fetch until redirect
      prog[2] = W_JALR;
      knobs(100, 0, 0, 0);
      clr_mode = 1; clr_pc = 32'h0;
      repeat (12) cycle();
      check("jalr_hold_req", bus._mem_req, 64'd0);
      clr_mode = 1; clr_pc = 32'h100;
      cycle();
      cycle();
      check("redir_req",  bus._mem_req,  64'd1);
      check("redir_addr", bus._mem_addr, 32'h100);
      repeat (6) cycle();

      // flush while a request waits; response arrives after the flush
      knobs(100, 0, 1, 1);
      clr_mode = 2; clr_pc = 32'h200;
      for (int i = 0; i < 20 && clr_mode != 0; i++) cycle();
      cycle();
      check("drop_noreq", bus._mem_req, 64'd0);
      cycle();
      check("drop_req",   bus._mem_req,      64'd1);
      check("drop_addr",  bus._mem_addr,     32'h200);
      check("drop_count", bus._queue_count,  64'd0);

      // flush in the same cycle as the response
      clr_mode = 3; clr_pc = 32'h300;
      for (int i = 0; i < 20 && clr_mode != 0; i++) cycle();
      cycle();
      check("clrvalid_req",  bus._mem_req,  64'd1);
      check("clrvalid_addr", bus._mem_addr, 32'h300);
      repeat (4) cycle();
      clr_mode = 0;

      // JAL at 0x20
      prog[8] = W_JAL;
      knobs(0, 0, 0, 0);
      clr_mode = 1; clr_pc = 32'h20;
      for (int i = 0; i < 10; i++) cycle();
`ifdef FETCH_JAL_PREDICT_EN
      check("jal_pred", bus._inst_pred_pc, 32'h120);
`else
      check("jal_pred", bus._inst_pred_pc, 32'h24);
`endif
      check("jal_head", bus._inst, W_JAL);

      // pause with two entries queued
      knobs(0, 0, 0, 1);
      clr_mode = 1; clr_pc = 32'h40;
      cycle();
      pause_at = 2;
      for (int i = 0; i < 30 && pause_at >= 0; i++) cycle();
      check("pause_vld", bus._inst_valid, 64'd0);
      check("pause_req", bus._mem_req,    64'd0);
      cycle();
      cycle();
      cycle();
      check("resume_count", bus._queue_count, 64'd2);
      check("resume_head",  bus._inst_addr,   32'h40);
      check("resume_vld",   bus._inst_valid,  64'd1);

      // randomized traffic with flushes, pauses and occasional reset
      for (int blk = 0; blk < 10; blk++) begin
         knobs($urandom_range(20, 100), $urandom_range(0, 50), 0, $urandom_range(0, 4));
         p_clear = $urandom_range(0, 30);
         p_pause = $urandom_range(0, 15);
         for (int c = 0; c < 200; c++) begin
            if (rst_cycles == 0 && $urandom_range(999) < 3) rst_cycles = 2;
            cycle();
         end
      end

      @(negedge clk_in);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
